// File: rtl/project_select_sequencer_if.sv
// Wishbone slave bus between the host and the project select sequencer.
interface project_select_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/project_select_sequencer.sv
// Pad-sharing controller: every selection change disconnects the pads, holds the
// new project in reset, then connects it. All outputs come straight from flops.
module project_select_sequencer #(
  parameter int          NUM_PROJECTS   = 4,
  parameter logic [31:0] ADDR_SELECT    = 32'h3000_0000,
  parameter logic [31:0] ADDR_STATUS    = 32'h3000_0008,
  parameter int          QUIESCE_CYCLES = 4,
  parameter int          RESET_CYCLES   = 16,
  localparam int         SEL_W          = $clog2(NUM_PROJECTS)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  project_select_sequencer_if.slave wb,
  output logic [SEL_W-1:0]        proj_sel,
  output logic                    proj_active,
  output logic [NUM_PROJECTS-1:0] proj_reset,
  output logic                    busy
);

  localparam int CNT_MAX = (QUIESCE_CYCLES > RESET_CYCLES) ? QUIESCE_CYCLES : RESET_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_QUIESCE = 2'd1, S_RESET = 2'd2, S_RUN = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic                    bad_q, bad_d;
  logic                    drop_q, drop_d;
  logic                    en_q, en_d;
  logic [7:0]              idx_q, idx_d;
  logic                    start_q, start_d;
  logic [SEL_W-1:0]        proj_sel_q, proj_sel_d;
  logic                    proj_active_q, proj_active_d;
  logic [NUM_PROJECTS-1:0] proj_reset_q, proj_reset_d;
  logic                    busy_q, busy_d;

  // Bus decode. A known-address access is taken only while ack is low, which
  // turns ack into a one-cycle pulse even if the master keeps strobing.
  logic valid, wr, rd, hit_sel, hit_sts, accept, sel_wr, idx_ok, sts_rd;
  logic unused_dat;

  assign valid   = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign wr      = valid & wb.wbs_we_i & (|wb.wbs_sel_i);
  assign rd      = valid & ~wb.wbs_we_i;
  assign hit_sel = (wb.wbs_adr_i == ADDR_SELECT);
  assign hit_sts = (wb.wbs_adr_i == ADDR_STATUS);
  assign accept  = (wr | rd) & (hit_sel | hit_sts) & ~ack_q;
  assign sel_wr  = accept & wr & hit_sel & wb.wbs_sel_i[1] & wb.wbs_sel_i[0];
  assign idx_ok  = ({24'b0, wb.wbs_dat_i[7:0]} < 32'(NUM_PROJECTS));
  assign sts_rd  = accept & rd & hit_sts;
  assign unused_dat = ^wb.wbs_dat_i[31:9];

  // Register file: ack/read data, sticky flags (set beats clear) and the select latch.
  always_comb begin
    ack_d   = accept;
    dat_d   = 32'b0;
    if (accept & rd) begin
      if (hit_sel) dat_d = {23'b0, en_q, idx_q};
      else         dat_d = {26'b0, state_q, proj_active_q, bad_q, drop_q, busy_q};
    end
    bad_d   = (sel_wr & ~idx_ok) | (bad_q & ~sts_rd);
    drop_d  = (sel_wr & idx_ok & busy_q) | (drop_q & ~sts_rd);
    start_d = sel_wr & idx_ok & ~busy_q;
    en_d    = start_d ? wb.wbs_dat_i[8]   : en_q;
    idx_d   = start_d ? wb.wbs_dat_i[7:0] : idx_q;
  end

  // Bus-side register updates.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'b0;
      bad_q   <= 1'b0;
      drop_q  <= 1'b0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      idx_q   <= 8'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      bad_q   <= bad_d;
      drop_q  <= drop_d;
      start_q <= start_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
    end
  end

  // Sequencer state register and dwell counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the write's start pulse lands one cycle after the accept edge,
  // and each timed state loads its dwell minus one and leaves when it hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start_q) begin
          state_d = S_QUIESCE;
          cnt_d   = CW'(QUIESCE_CYCLES - 1);
        end
      end
      S_QUIESCE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (en_q) begin
          state_d = S_RESET;
          cnt_d   = CW'(RESET_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_RUN;
      end
    endcase
  end

  // Output values for the next state; the mux select only moves on RESET entry,
  // when the pads are already disconnected.
  always_comb begin
    proj_sel_d    = ((state_d == S_RESET) && (state_q != S_RESET)) ? idx_q[SEL_W-1:0] : proj_sel_q;
    proj_active_d = (state_d == S_RUN);
    busy_d        = (state_d == S_QUIESCE) || (state_d == S_RESET);
    proj_reset_d  = '1;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      proj_reset_d[i] = !((state_d == S_RUN) && (proj_sel_d == SEL_W'(i)));
    end
  end

  // Registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      proj_sel_q    <= '0;
      proj_active_q <= 1'b0;
      proj_reset_q  <= '1;
      busy_q        <= 1'b0;
    end else begin
      proj_sel_q    <= proj_sel_d;
      proj_active_q <= proj_active_d;
      proj_reset_q  <= proj_reset_d;
      busy_q        <= busy_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign proj_sel     = proj_sel_q;
  assign proj_active  = proj_active_q;
  assign proj_reset   = proj_reset_q;
  assign busy         = busy_q;

endmodule
